// File: rtl/score_vector_collector_if.sv
// rtl/score_vector_collector_if.sv - score beat input stream and packed score vector output bundle
//
// Signals:
//   in_valid/in_ready/in_data : serial signed accumulator beats, class order 0..N_SCORES-1
//   arr_out/out_valid/out_ack : packed unsigned score vector, held until acknowledged
//   max_idx                   : argmax of the held vector (only with SCORE_COLLECT_ARGMAX_EN)
// Modports: slave = collector side, master = producer/consumer side.
// Optional macro: SCORE_COLLECT_ARGMAX_EN
interface score_vector_collector_if #(
    parameter int N_SCORES = 10,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 8
);
    localparam int CW = (N_SCORES > 1) ? $clog2(N_SCORES) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [IN_W-1:0]           in_data;
    logic [N_SCORES*OUT_W-1:0] arr_out;
    logic                      out_valid;
    logic                      out_ack;
`ifdef SCORE_COLLECT_ARGMAX_EN
    logic [CW-1:0]             max_idx;

    modport slave  (input in_valid, in_data, out_ack,
                    output in_ready, arr_out, out_valid, max_idx);
    modport master (output in_valid, in_data, out_ack,
                    input in_ready, arr_out, out_valid, max_idx);
`else
    modport slave  (input in_valid, in_data, out_ack,
                    output in_ready, arr_out, out_valid);
    modport master (output in_valid, in_data, out_ack,
                    input in_ready, arr_out, out_valid);
`endif
endinterface

// File: rtl/score_vector_collector.sv
// rtl/score_vector_collector.sv - collects, quantizes and packs N_SCORES class scores into one vector
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any frame in progress
//   start : begin a new frame, honoured only in IDLE
//   busy  : high whenever the collector is not IDLE
//   bus   : score_vector_collector_if.slave (beat input, packed vector output)
// Optional macro: SCORE_COLLECT_ARGMAX_EN adds running argmax tracking on bus.max_idx.
module score_vector_collector #(
    parameter int N_SCORES = 10,
    parameter int IN_W     = 16,
    parameter int SHIFT    = 4,
    parameter int OUT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    score_vector_collector_if.slave bus
);
    localparam int CW = (N_SCORES > 1) ? $clog2(N_SCORES) : 1;
    localparam logic [IN_W-1:0] SAT = IN_W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             count;
    logic [N_SCORES*OUT_W-1:0] arr_q;
    logic [IN_W-1:0]           shifted;
    logic [OUT_W-1:0]          q;
    logic                      accept;
    logic                      last_beat;
    logic                      enter_collect;

    assign accept        = bus.in_valid & bus.in_ready;
    assign last_beat     = (count == CW'(N_SCORES - 1));
    assign enter_collect = (state == IDLE) & start;
    assign bus.arr_out   = arr_q;

    // ReLU, scale down, then saturate to the unsigned score range.
    always_comb begin
        shifted = bus.in_data >> SHIFT;
        if (bus.in_data[IN_W-1]) begin
            q = '0;
        end else if (shifted > SAT) begin
            q = '1;
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (accept && last_beat) state_nxt = HOLD;
            HOLD:    if (bus.out_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and in_ready drops the cycle after the last accept.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            COLLECT: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            arr_q <= '0;
        end else if (enter_collect) begin
            count <= '0;
            arr_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_SCORES; k++) begin
                if (count == CW'(k)) begin
                    arr_q[k*OUT_W +: OUT_W] <= q;
                end
            end
            count <= last_beat ? '0 : count + 1'b1;
        end
    end

`ifdef SCORE_COLLECT_ARGMAX_EN
    logic [OUT_W-1:0] run_max;
    logic [CW-1:0]    max_idx_q;

    assign bus.max_idx = max_idx_q;

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max   <= '0;
            max_idx_q <= '0;
        end else if (enter_collect) begin
            run_max   <= '0;
            max_idx_q <= '0;
        end else if (accept && (q > run_max)) begin
            run_max   <= q;
            max_idx_q <= count;
        end
    end
`endif

endmodule

// File: tb/tb_score_vector_collector.sv
// tb/tb_score_vector_collector.sv - randomized self-checking bench for score_vector_collector
module tb_score_vector_collector;
    localparam int N     = 10;
    localparam int IN_W  = 16;
    localparam int SHIFT = 4;
    localparam int OUT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    score_vector_collector_if #(.N_SCORES(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    score_vector_collector #(.N_SCORES(N), .IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int                 vals [N];
    logic [N*OUT_W-1:0] exp_arr;
    int                 exp_idx;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int quant(input int x);
        int v;
        if (x < 0) return 0;
        v = x / (1 << SHIFT);
        if (v > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return v;
    endfunction

    function automatic void build_expected();
        exp_arr = '0;
        exp_idx = 0;
        for (int k = 0; k < N; k++) begin
            exp_arr[k*OUT_W +: OUT_W] = OUT_W'(quant(vals[k]));
            if (quant(vals[k]) > quant(vals[exp_idx])) exp_idx = k;
        end
    endfunction

    task automatic rand_vals();
        logic signed [IN_W-1:0] r;
        for (int k = 0; k < N; k++) begin
            r = IN_W'($urandom);
            if ($urandom_range(0, 2) == 0) r = r >>> 4;
            vals[k] = int'(r);
        end
    endtask

    // mode 0: back-to-back, 1: valid toggles 1/0, 2: random valid with stray out_ack
    task automatic run_frame(input int mode);
        int idx;
        int cyc;
        logic tog;
        logic v;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("collect_busy", busy, 1'b1);
        check("collect_ready", bus.in_ready, 1'b1);
        check("collect_arr_clear", bus.arr_out, '0);
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        while (idx < N && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'(($urandom_range(0, 1)));
            tog = ~tog;
            bus.in_valid = v;
            bus.in_data  = v ? IN_W'(vals[idx]) : IN_W'($urandom);
            bus.out_ack  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v && bus.in_ready) idx++;
            cyc++;
            @(negedge clk);
            if (idx < N) check("out_valid_early", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.out_ack  = 1'b0;
        check("beats_accepted", idx, N);
        check("out_valid_latency", bus.out_valid, 1'b1);
        check("hold_ready_low", bus.in_ready, 1'b0);
        check("arr_out", bus.arr_out, exp_arr);
`ifdef SCORE_COLLECT_ARGMAX_EN
        check("max_idx", bus.max_idx, exp_idx);
`endif
    endtask

    task automatic hold_and_ack(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            start        = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = IN_W'($urandom);
            bus.out_ack  = 1'b0;
            @(negedge clk);
            check("hold_arr", bus.arr_out, exp_arr);
            check("hold_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0;
        bus.out_ack  = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        start       = 1'b0;
        check("ack_valid_drop", bus.out_valid, 1'b0);
        check("ack_idle", busy, 1'b0);
        check("ack_arr_kept", bus.arr_out, exp_arr);
        @(negedge clk);
        check("start_with_ack_ignored", busy, 1'b0);
`ifdef SCORE_COLLECT_ARGMAX_EN
        check("max_idx_kept", bus.max_idx, exp_idx);
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ack  = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_arr", bus.arr_out, '0);
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) vals[k] = (k + 1) * 32'h100;
        run_frame(0);
        check("ramp_const", bus.arr_out, 80'hA0_90_80_70_60_50_40_30_20_10);
        hold_and_ack(20);

        vals = '{-5, 32'h7FFF, 32'h0FF0, 32'h1000, 32'h000F, 0, 0, 0, 0, 0};
        run_frame(0);
        check("sat_const", bus.arr_out, 80'h00_00_00_00_00_00_FF_FF_FF_00);
        hold_and_ack(3);

        for (int k = 0; k < N; k++) vals[k] = (k + 1) * 32'h100;
        run_frame(1);
        hold_and_ack(2);

        // Mid-frame reset: six beats then asynchronous abort.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IN_W'(32'h7F00);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_arr", bus.arr_out, '0);
        check("abort_ready", bus.in_ready, 1'b0);
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
`ifdef SCORE_COLLECT_ARGMAX_EN
        check("abort_max_idx", bus.max_idx, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        rand_vals();
        run_frame(2);
        hold_and_ack(1);

        vals = '{32'h300, 32'h900, 32'h500, 32'h900, 0, 0, 0, 0, 0, 0};
        run_frame(0);
        hold_and_ack(1);
        vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(2);
        hold_and_ack(1);

        for (int f = 0; f < 6; f++) begin
            rand_vals();
            run_frame(f % 3);
            hold_and_ack(int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
